// File: rtl/banked_memory_ctrl_pkg.sv
// Shared types and constants for the banked switch/button memory controller.
// Holds the FSM encoding, default widths and a counter-width helper.
package banked_memory_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_ADDR_W       = 2;
  localparam int DEF_DEBOUNCE_CYC = 4;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/banked_memory_ctrl_if.sv
// Board-side bus of the memory controller: switch/button inputs and LED readout.
interface banked_memory_ctrl_if
  import banked_memory_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [DATA_W-1:0] data;
  logic              store;
  logic              clear;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] memory;
  logic              valid;
  logic              busy;
  logic              wr_ack;

  modport master (
    output data, store, clear, addr,
    input  memory, valid, busy, wr_ack
  );

  modport slave (
    input  data, store, clear, addr,
    output memory, valid, busy, wr_ack
  );

endinterface

// File: rtl/banked_memory_ctrl_button_conditioner.sv
// Raw button -> two-flop synchroniser -> optional debouncer -> rising-edge pulse.
// DEBOUNCE_CYC = 0 passes the synchronised level straight through.
module button_conditioner
  import banked_memory_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    prev_d  = level;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  generate
    if (DEBOUNCE_CYC == 0) begin : g_bypass
      assign level = sync2_q;
    end else begin : g_debounce
      localparam int CW = cnt_width(DEBOUNCE_CYC);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

      logic [CW-1:0] cnt_q, cnt_d;
      logic          deb_q, deb_d;

      // Count consecutive cycles of disagreement; any agreeing cycle restarts it.
      always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
          if (cnt_q == LAST) begin
            deb_d = sync2_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q <= '0;
          deb_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          deb_q <= deb_d;
        end
      end

      assign level = deb_q;
    end
  endgenerate

  assign rise = level & ~prev_q;

endmodule

// File: rtl/banked_memory_ctrl.sv
// DEPTH-word switch/button memory with per-word valid bits, a write acknowledge
// and a one-word-per-cycle clear-all sweep.
module banked_memory_ctrl
  import banked_memory_ctrl_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input logic                clk,
  input logic                reset,
  banked_memory_ctrl_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic              wr_ack_q, wr_ack_d;

  logic store_level, store_rise;
  logic clear_level, clear_rise;
  logic wr_en, sweep_en;
  logic unused_levels;

  button_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_store_cond (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.store),
    .level (store_level),
    .rise  (store_rise)
  );

  button_conditioner #(.DEBOUNCE_CYC(0)) u_clear_cond (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.clear),
    .level (clear_level),
    .rise  (clear_rise)
  );

  assign unused_levels = store_level ^ clear_level;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      mem_q    <= '{default: '0};
      valid_q  <= '0;
      wr_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mem_q    <= mem_d;
      valid_q  <= valid_d;
      wr_ack_q <= wr_ack_d;
    end
  end

  // A clear edge takes priority; a clear edge during the sweep is simply ignored.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_rise) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_en    = (state_q == ST_IDLE) && store_rise && !clear_rise;
    sweep_en = (state_q == ST_CLEAR);
    wr_ack_d = wr_en;
  end

  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    if (wr_en) begin
      mem_d[bus.addr]   = bus.data;
      valid_d[bus.addr] = 1'b1;
    end
    if (sweep_en) begin
      mem_d[idx_q]   = '0;
      valid_d[idx_q] = 1'b0;
    end
  end

  assign bus.memory = mem_q[bus.addr];
  assign bus.valid  = valid_q[bus.addr];
  assign bus.busy   = sweep_en;
  assign bus.wr_ack = wr_ack_q;

endmodule

// File: tb/tb_banked_memory_ctrl.sv
// Self-checking bench for banked_memory_ctrl: directed scenarios with hand-computed
// expectations, then randomized traffic, all compared every cycle against a model.
module tb_banked_memory_ctrl;

  import banked_memory_ctrl_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int DEB    = 4;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  banked_memory_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  banked_memory_ctrl #(
    .DATA_W       (DATA_W),
    .ADDR_W       (ADDR_W),
    .DEBOUNCE_CYC (DEB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int passCount  = 0;
  int checkCount = 0;
  bit chkEn      = 1'b0;

  // Behavioural model: words, valid flags, sweep progress and the button pipelines.
  int mMem [DEPTH];
  bit mVld [DEPTH];
  bit mSweep;
  int mIdx;
  bit mAck;
  bit s1, s2, prevLvl, deb;
  bit c1, c2, cPrev;
  bit win [DEB];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Drive every board input at once; called in the quiet phase after a rising edge.
  task automatic applyStimulus(input bit st, input bit cl, input logic [7:0] d, input logic [1:0] a);
    bus.store = st;
    bus.clear = cl;
    bus.data  = d;
    bus.addr  = a;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic readCheck(input string name, input logic [1:0] a, input logic [7:0] expMem, input bit expVld);
    bus.addr = a;
    #1;
    checkOutput({name, "_mem"}, bus.memory, expMem);
    checkOutput({name, "_vld"}, bus.valid, expVld);
  endtask

  task automatic writeWord(input logic [1:0] a, input logic [7:0] d);
    applyStimulus(1'b1, 1'b0, d, a);
    step(8);
    bus.store = 1'b0;
    step(8);
  endtask

  // Reference model advanced once per rising edge using the inputs held at that edge.
  always @(posedge clk) begin : model
    bit lvl, rs, rc, ackNext, allDiff;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mMem[i] = 0;
        mVld[i] = 1'b0;
      end
      for (int i = 0; i < DEB; i++) win[i] = 1'b0;
      mSweep = 0; mIdx = 0; mAck = 0;
      s1 = 0; s2 = 0; prevLvl = 0; deb = 0;
      c1 = 0; c2 = 0; cPrev = 0;
    end else begin
      lvl     = deb;
      rs      = lvl && !prevLvl;
      rc      = c2 && !cPrev;
      ackNext = 1'b0;
      if (!mSweep) begin
        if (rc) begin
          mSweep = 1'b1;
          mIdx   = 0;
        end else if (rs) begin
          mMem[bus.addr] = bus.data;
          mVld[bus.addr] = 1'b1;
          ackNext        = 1'b1;
        end
      end else begin
        mMem[mIdx] = 0;
        mVld[mIdx] = 1'b0;
        if (mIdx == DEPTH - 1) mSweep = 1'b0;
        mIdx++;
      end
      mAck    = ackNext;
      prevLvl = lvl;
      cPrev   = c2;
      // Debounced level flips once the last DEB synced samples all disagree with it.
      for (int i = DEB - 1; i > 0; i--) win[i] = win[i-1];
      win[0]  = s2;
      allDiff = 1'b1;
      for (int i = 0; i < DEB; i++) if (win[i] == deb) allDiff = 1'b0;
      if (allDiff) deb = !deb;
      s2 = s1;
      s1 = bus.store;
      c2 = c1;
      c1 = bus.clear;
    end
  end

  // Every falling edge: all four outputs against the model.
  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("cyc_memory", bus.memory, mMem[bus.addr]);
      checkOutput("cyc_valid",  bus.valid,  mVld[bus.addr]);
      checkOutput("cyc_busy",   bus.busy,   mSweep);
      checkOutput("cyc_wr_ack", bus.wr_ack, mAck);
    end
  end

  initial begin : stimulus
    int ackCnt, ackAt, busyCnt, runLeft;
    logic [7:0] pat [4];
    int pulses [6];
    pat    = '{8'h11, 8'h22, 8'h33, 8'h44};
    pulses = '{1, 2, 3, 1, 2, 3};

    // 1. reset state
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 2'd0);
    step(3);
    chkEn = 1'b1;
    reset = 1'b0;
    for (int a = 0; a < DEPTH; a++) readCheck("t1_reset", a[1:0], 8'h00, 1'b0);
    checkOutput("t1_busy", bus.busy, 1'b0);
    checkOutput("t1_ack",  bus.wr_ack, 1'b0);

    // 2. long press: one write, acknowledged 7 cycles after the raw rise
    applyStimulus(1'b1, 1'b0, 8'hA5, 2'd2);
    ackCnt = 0; ackAt = -1;
    for (int c = 1; c <= 20; c++) begin
      step(1);
      if (bus.wr_ack) begin
        ackCnt++;
        ackAt = c;
      end
    end
    checkOutput("t2_ack_count", ackCnt, 1);
    checkOutput("t2_ack_cycle", ackAt, 7);
    bus.store = 1'b0;
    step(8);
    readCheck("t2_addr2", 2'd2, 8'hA5, 1'b1);
    readCheck("t2_addr0", 2'd0, 8'h00, 1'b0);
    readCheck("t2_addr1", 2'd1, 8'h00, 1'b0);
    readCheck("t2_addr3", 2'd3, 8'h00, 1'b0);

    // 3. short glitches are rejected, a clean 6-cycle press writes once
    ackCnt = 0;
    applyStimulus(1'b0, 1'b0, 8'hE7, 2'd1);
    foreach (pulses[i]) begin
      bus.store = 1'b1;
      for (int c = 0; c < pulses[i]; c++) begin step(1); if (bus.wr_ack) ackCnt++; end
      bus.store = 1'b0;
      for (int c = 0; c < 2; c++) begin step(1); if (bus.wr_ack) ackCnt++; end
    end
    for (int c = 0; c < 8; c++) begin step(1); if (bus.wr_ack) ackCnt++; end
    checkOutput("t3_glitch_ack", ackCnt, 0);
    readCheck("t3_glitch_word", 2'd1, 8'h00, 1'b0);
    ackCnt = 0;
    applyStimulus(1'b1, 1'b0, 8'h3C, 2'd1);
    for (int c = 0; c < 6; c++) begin step(1); if (bus.wr_ack) ackCnt++; end
    bus.store = 1'b0;
    for (int c = 0; c < 8; c++) begin step(1); if (bus.wr_ack) ackCnt++; end
    checkOutput("t3_clean_ack", ackCnt, 1);
    readCheck("t3_clean_word", 2'd1, 8'h3C, 1'b1);

    // 4. fill every word, then a clear sweep is busy for exactly DEPTH cycles
    for (int a = 0; a < DEPTH; a++) writeWord(a[1:0], pat[a]);
    for (int a = 0; a < DEPTH; a++) readCheck("t4_filled", a[1:0], pat[a], 1'b1);
    busyCnt = 0;
    applyStimulus(1'b0, 1'b1, 8'h00, 2'd0);
    step(1);
    bus.clear = 1'b0;
    for (int c = 0; c < 12; c++) begin step(1); if (bus.busy) busyCnt++; end
    checkOutput("t4_busy_cycles", busyCnt, 4);
    for (int a = 0; a < DEPTH; a++) readCheck("t4_cleared", a[1:0], 8'h00, 1'b0);

    // 5a. a store commit landing inside the sweep is dropped
    ackCnt = 0; busyCnt = 0;
    applyStimulus(1'b1, 1'b1, 8'h77, 2'd3);
    step(1);
    bus.clear = 1'b0;
    for (int c = 0; c < 15; c++) begin
      step(1);
      if (bus.wr_ack) ackCnt++;
      if (bus.busy) busyCnt++;
    end
    bus.store = 1'b0;
    step(8);
    checkOutput("t5a_ack", ackCnt, 0);
    checkOutput("t5a_busy", busyCnt, 4);
    readCheck("t5a_word", 2'd3, 8'h00, 1'b0);

    // 5b. clear and write request in the same cycle: the clear wins
    writeWord(2'd1, 8'h5A);
    ackCnt = 0; busyCnt = 0;
    applyStimulus(1'b1, 1'b0, 8'h66, 2'd2);
    step(4);
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    for (int c = 0; c < 14; c++) begin
      step(1);
      if (bus.wr_ack) ackCnt++;
      if (bus.busy) busyCnt++;
    end
    bus.store = 1'b0;
    step(8);
    checkOutput("t5b_ack", ackCnt, 0);
    checkOutput("t5b_busy", busyCnt, 4);
    readCheck("t5b_word2", 2'd2, 8'h00, 1'b0);
    readCheck("t5b_word1", 2'd1, 8'h00, 1'b0);

    // 6. reset two cycles into a sweep aborts it
    writeWord(2'd3, 8'h44);
    applyStimulus(1'b0, 1'b1, 8'h00, 2'd3);
    step(1);
    bus.clear = 1'b0;
    step(3);
    checkOutput("t6_busy_before", bus.busy, 1'b1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checkOutput("t6_busy_after", bus.busy, 1'b0);
    for (int a = 0; a < DEPTH; a++) readCheck("t6_reset", a[1:0], 8'h00, 1'b0);
    step(1);
    checkOutput("t6_busy_idle", bus.busy, 1'b0);

    // Randomized traffic: store held in random runs, rare clears and resets
    runLeft = 0;
    for (int c = 0; c < 1500; c++) begin
      if (runLeft == 0) begin
        bus.store = 1'($urandom_range(0, 1));
        runLeft   = $urandom_range(1, 10);
      end
      runLeft--;
      bus.clear = ($urandom_range(0, 40) == 0);
      bus.data  = 8'($urandom);
      bus.addr  = 2'($urandom);
      reset     = ($urandom_range(0, 300) == 0);
      step(1);
    end
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 2'd0);
    step(4);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
